// File: rtl/axi_boundary_burst_splitter.sv
// ---------------------------------------------------------------------------
// axi_boundary_burst_splitter
//
// Takes one transfer request (start address, byte count, channel ID) and
// emits it as a sequence of segments. No segment crosses a 2^BOUND_LOG2 byte
// boundary, and no segment is larger than MAX_MTU bytes. The channel ID is
// carried through untouched so the downstream read/write command generators
// can steer on it.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready     request handshake; req_ready is high only in IDLE
//   req_addr/bytes/id       request start address, total bytes, channel tag
//   seg_valid/seg_ready     segment handshake; fields hold while stalled
//   seg_addr/bytes/id       segment start address, size (1..MAX_MTU), tag
//   seg_first/last/idx      position of the segment within its request
//   busy                    a request is being split
//   done                    high during the handshake of the last segment
//   zero_len_err            one-cycle pulse when a zero-byte request is dropped
// ---------------------------------------------------------------------------
module axi_boundary_burst_splitter #(
    parameter int ADDR_W     = 64,
    parameter int LEN_W      = 16,
    parameter int BOUND_LOG2 = 12,
    parameter int MAX_MTU    = 512,
    parameter int ID_W       = 2,
    localparam int SEG_W     = $clog2(MAX_MTU) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_bytes,
    input  logic [ID_W-1:0]   req_id,
    output logic              seg_valid,
    input  logic              seg_ready,
    output logic [ADDR_W-1:0] seg_addr,
    output logic [SEG_W-1:0]  seg_bytes,
    output logic [ID_W-1:0]   seg_id,
    output logic              seg_first,
    output logic              seg_last,
    output logic [LEN_W-1:0]  seg_idx,
    output logic              busy,
    output logic              done,
    output logic              zero_len_err
);

    // Width wide enough to compare the remaining count, the distance to the
    // next boundary (which can equal the full boundary span) and the MTU.
    localparam int CMP_W = (LEN_W > BOUND_LOG2 + 1) ? LEN_W : BOUND_LOG2 + 1;
    localparam logic [BOUND_LOG2:0] BND_SPAN = {1'b1, {BOUND_LOG2{1'b0}}};
    localparam logic [CMP_W-1:0]    MTU_X    = CMP_W'(MAX_MTU);

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t            state;
    logic [LEN_W-1:0]  rem;

    logic              accept;
    logic              seg_hs;
    logic [SEG_W-1:0]  acc_size;
    logic [ADDR_W-1:0] nxt_addr;
    logic [LEN_W-1:0]  nxt_rem;
    logic [SEG_W-1:0]  nxt_size;

    // Size of the segment starting at address a with r bytes still to go:
    // min(r, bytes to next boundary, MAX_MTU). The result always fits in
    // SEG_W because it never exceeds MAX_MTU.
    function automatic logic [SEG_W-1:0] seg_size(input logic [ADDR_W-1:0] a,
                                                  input logic [LEN_W-1:0]  r);
        logic [BOUND_LOG2:0] to_bound;
        logic [CMP_W-1:0]    r_x;
        logic [CMP_W-1:0]    tb_x;
        logic [CMP_W-1:0]    m;
        to_bound = BND_SPAN - {1'b0, a[BOUND_LOG2-1:0]};
        r_x      = CMP_W'(r);
        tb_x     = CMP_W'(to_bound);
        m        = r_x;
        if (tb_x < m)  m = tb_x;
        if (MTU_X < m) m = MTU_X;
        return m[SEG_W-1:0];
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = (state == SPLIT);
    assign accept    = req_valid && req_ready;
    assign seg_hs    = seg_valid && seg_ready;
    // Gated by reset so a handshake coinciding with reset never reports done.
    assign done      = seg_hs && seg_last && !reset;

    assign acc_size  = seg_size(req_addr, req_bytes);
    // Address arithmetic wraps naturally at 2^ADDR_W.
    assign nxt_addr  = seg_addr + ADDR_W'(seg_bytes);
    assign nxt_rem   = rem - LEN_W'(seg_bytes);
    assign nxt_size  = seg_size(nxt_addr, nxt_rem);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rem          <= '0;
            seg_valid    <= 1'b0;
            seg_addr     <= '0;
            seg_bytes    <= '0;
            seg_id       <= '0;
            seg_first    <= 1'b0;
            seg_last     <= 1'b0;
            seg_idx      <= '0;
            zero_len_err <= 1'b0;
        end else begin
            zero_len_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_bytes == '0) begin
                            zero_len_err <= 1'b1;
                        end else begin
                            state     <= SPLIT;
                            rem       <= req_bytes;
                            seg_valid <= 1'b1;
                            seg_addr  <= req_addr;
                            seg_bytes <= acc_size;
                            seg_id    <= req_id;
                            seg_first <= 1'b1;
                            seg_last  <= (CMP_W'(acc_size) == CMP_W'(req_bytes));
                            seg_idx   <= '0;
                        end
                    end
                end
                SPLIT: begin
                    // Output fields only move on a handshake, so they stay
                    // frozen for as long as the consumer stalls.
                    if (seg_hs) begin
                        if (seg_last) begin
                            state     <= IDLE;
                            seg_valid <= 1'b0;
                            seg_first <= 1'b0;
                            seg_last  <= 1'b0;
                        end else begin
                            rem       <= nxt_rem;
                            seg_addr  <= nxt_addr;
                            seg_bytes <= nxt_size;
                            seg_first <= 1'b0;
                            seg_last  <= (CMP_W'(nxt_size) == CMP_W'(nxt_rem));
                            seg_idx   <= seg_idx + LEN_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_boundary_burst_splitter.md
Name: axi_boundary_burst_splitter

Overview:
Parametrised successor to the 4 KB address aligner. Accepts one transfer request (address, byte count, channel ID) over a valid/ready handshake. Emits a sequence of segments, none of which crosses a 2^BOUND_LOG2 boundary or exceeds MAX_MTU bytes. It sits between the submaster grant logic and the AXI read/write command generators; the channel ID replaces the separate rd/wr grant flags.

Parameters:
ADDR_W, 64, address width in bits
LEN_W, 16, request byte-count width (max request = 2^LEN_W-1 bytes)
BOUND_LOG2, 12, log2 of the no-cross boundary (12 = 4 KB)
MAX_MTU, 512, max bytes per segment; power of two, must be <= 2^BOUND_LOG2
ID_W, 2, channel ID width (bit0 = rd, bit1 = wr by convention; passed through untouched)
SEG_W, derived clog2(MAX_MTU)+1, segment byte-count width (localparam)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept request
req_addr  in  ADDR_W  start byte address
req_bytes  in  LEN_W  total bytes
req_id  in  ID_W  channel tag
seg_valid  out  1  segment output valid
seg_ready  in  1  downstream accepts segment
seg_addr  out  ADDR_W  segment start address
seg_bytes  out  SEG_W  segment byte count, 1..MAX_MTU
seg_id  out  ID_W  copy of req_id
seg_first  out  1  first segment of request
seg_last  out  1  final segment of request
seg_idx  out  LEN_W  segment index within request, 0-based
busy  out  1  request in progress
done  out  1  one-cycle pulse on last segment handshake
zero_len_err  out  1  one-cycle pulse: zero-byte request dropped

Behaviour:
- Reset: state IDLE; req_ready=1 after reset release; seg_valid, seg_first, seg_last, busy, done, zero_len_err = 0; seg_addr, seg_bytes, seg_id, seg_idx = 0.
- States: IDLE, SPLIT.
- req_ready = (state==IDLE). A request is accepted on a cycle with req_valid & req_ready.
- IDLE, accept, req_bytes==0: pulse zero_len_err next cycle, emit no segment, stay IDLE.
- IDLE, accept, req_bytes>0: latch cur_addr=req_addr, rem=req_bytes, id; go to SPLIT. Next cycle: seg_valid=1, seg_first=1, seg_idx=0. Latency is 1 cycle, request handshake to first seg_valid.
- Segment size: seg_bytes = min(rem, to_bound, MAX_MTU).
  - to_bound = 2^BOUND_LOG2 - cur_addr[BOUND_LOG2-1:0], computed in BOUND_LOG2+1 bits, range 1..2^BOUND_LOG2.
  - Comparisons are done at max(LEN_W, BOUND_LOG2+1) bits, zero-extended.
- Output registers are stable while seg_valid & !seg_ready; no field may change until handshake.
- On handshake (seg_valid & seg_ready):
  - cur_addr += seg_bytes, modulo 2^ADDR_W (address wraps to 0, no error).
  - rem -= seg_bytes; seg_idx += 1; seg_first=0.
  - Next segment is valid on the following cycle, giving 1 segment per cycle under continuous seg_ready.
- seg_last = (seg_bytes == rem). On the last handshake: done=1 in the same cycle (combinational on handshake), seg_valid falls next cycle, state returns to IDLE, and req_ready=1 from the next cycle.
- busy = (state==SPLIT).
- req_valid while busy is ignored (req_ready=0); the requester must hold the request.
- reset asserted mid-request: segment output and request are discarded; all outputs take reset values on the next edge. No partial done.

Test Plan:
- req_addr=0x0FF0, req_bytes=0x40, defaults -> segs (0x0FF0,16,first,idx0), (0x1000,48,last,idx1); done on 2nd handshake; req_ready back 1 cycle later.
- req_addr=0x2000, req_bytes=1300, seg_ready held 1 -> (0x2000,512), (0x2200,512), (0x2400,276,last) on 3 consecutive cycles.
- Same as previous with seg_ready toggling 1,0,0,1 -> outputs stable during stalls, same 3 segments, no drop or duplicate.
- req_addr=0xFFFF_FFFF_FFFF_FFF8, req_bytes=16 -> (…FFF8,8), (0x0,8,last); address wraps.
- req_bytes=0 -> zero_len_err pulse, no seg_valid; req_valid held during SPLIT of another request -> not accepted until IDLE.
- reset pulsed while 2nd of 3 segments is pending -> seg_valid=0, busy=0, req_ready=1 after reset release, no done pulse.
